// File: rtl/life_cell_update_pkg.sv
// Shared constants, state encoding and types for the Life next-generation engine.
package life_cell_update_pkg;

    localparam int unsigned COORD_W    = 8;
    localparam int unsigned NEIGH_CNT  = 9;
    localparam int unsigned CENTRE_IDX = 4;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_COUNT  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LAST    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
    } coord_t;

    // Life rule: birth on exactly 3 neighbours, survival on 2 or 3.
    function automatic logic life_rule(input logic self_alive, input logic [CNT_W-1:0] n);
        return (n == CNT_W'(3)) | (self_alive & (n == CNT_W'(2)));
    endfunction

endpackage

// File: rtl/life_neigh_addr.sv
// Combinational 3x3 neighbour address generator for index k = 0..8.
// LIFE_TORUS_EN selects wrap-around edges; otherwise edges clamp and flag oob.
module life_neigh_addr
    import life_cell_update_pkg::*;
#(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8
) (
    input  logic [COORD_W-1:0] base_c_i,
    input  logic [COORD_W-1:0] base_r_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [COORD_W-1:0] addr_c_o,
    output logic [COORD_W-1:0] addr_r_o,
    output logic               oob_o
);

    localparam logic [COORD_W-1:0] C_MAX = COORD_W'(MAP_WIDTH - 1);
    localparam logic [COORD_W-1:0] R_MAX = COORD_W'(MAP_HEIGHT - 1);

    logic [1:0]         dc_sel;
    logic [1:0]         dr_sel;
    logic [COORD_W-1:0] c_base;
    logic [COORD_W-1:0] r_base;
    logic               c_lo;
    logic               c_hi;
    logic               r_lo;
    logic               r_hi;
    logic [COORD_W-1:0] c_edge_lo;
    logic [COORD_W-1:0] c_edge_hi;
    logic [COORD_W-1:0] r_edge_lo;
    logic [COORD_W-1:0] r_edge_hi;

    always_comb begin
        dr_sel = 2'(idx_i / IDX_W'(3));
        dc_sel = 2'(idx_i % IDX_W'(3));
        // Keep a stray base coordinate on the board so reads never leave it.
        c_base = (base_c_i > C_MAX) ? C_MAX : base_c_i;
        r_base = (base_r_i > R_MAX) ? R_MAX : base_r_i;
        c_lo   = (dc_sel == 2'd0) && (c_base == '0);
        c_hi   = (dc_sel == 2'd2) && (c_base == C_MAX);
        r_lo   = (dr_sel == 2'd0) && (r_base == '0);
        r_hi   = (dr_sel == 2'd2) && (r_base == R_MAX);
`ifdef LIFE_TORUS_EN
        c_edge_lo = C_MAX;
        c_edge_hi = '0;
        r_edge_lo = R_MAX;
        r_edge_hi = '0;
        oob_o     = 1'b0;
`else
        c_edge_lo = '0;
        c_edge_hi = C_MAX;
        r_edge_lo = '0;
        r_edge_hi = R_MAX;
        oob_o     = c_lo | c_hi | r_lo | r_hi;
`endif
        case (dc_sel)
            2'd0:    addr_c_o = c_lo ? c_edge_lo : c_base - COORD_W'(1);
            2'd2:    addr_c_o = c_hi ? c_edge_hi : c_base + COORD_W'(1);
            default: addr_c_o = c_base;
        endcase
        case (dr_sel)
            2'd0:    addr_r_o = r_lo ? r_edge_lo : r_base - COORD_W'(1);
            2'd2:    addr_r_o = r_hi ? r_edge_hi : r_base + COORD_W'(1);
            default: addr_r_o = r_base;
        endcase
    end

endmodule

// File: rtl/life_cell_update.sv
// Life next-generation engine: per traverser cell, read 3x3 neighbourhood,
// apply the rule, write the next board, step the traverser. Edge mode via LIFE_TORUS_EN.
module life_cell_update
    import life_cell_update_pkg::*;
#(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] trav_addrC,
    input  logic [COORD_W-1:0] trav_addrR,
    input  logic               trav_finish,
    output logic               trav_enable,
    output logic [COORD_W-1:0] rd_addrC,
    output logic [COORD_W-1:0] rd_addrR,
    input  logic               rd_data,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_addrC,
    output logic [COORD_W-1:0] wr_addrR,
    output logic               wr_data,
    output logic               busy,
    output logic               gen_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEIGH_CNT - 1);
    localparam logic [IDX_W-1:0] CTR_IDX  = IDX_W'(CENTRE_IDX);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    coord_t             base_q, base_d;
    logic               last_cell_q, last_cell_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               self_q, self_d;
    logic               prev_oob_q, prev_oob_d;

    logic               trav_enable_q, trav_enable_d;
    logic               wr_en_q, wr_en_d;
    logic [COORD_W-1:0] wr_addrC_q, wr_addrC_d;
    logic [COORD_W-1:0] wr_addrR_q, wr_addrR_d;
    logic               wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               gen_done_q, gen_done_d;

    logic               fetch0;
    coord_t             base_sel;
    logic [COORD_W-1:0] nb_c;
    logic [COORD_W-1:0] nb_r;
    logic               nb_oob;
    logic               acc_en;
    logic               acc_live;
    logic [IDX_W-1:0]   acc_idx;

    // The traverser address is only valid in FETCH k=0, so that cycle reads it directly.
    assign fetch0   = (state_q == ST_FETCH) && (k_q == '0);
    assign base_sel = fetch0 ? '{col: trav_addrC, row: trav_addrR} : base_q;

    life_neigh_addr #(
        .MAP_WIDTH (MAP_WIDTH),
        .MAP_HEIGHT(MAP_HEIGHT)
    ) u_neigh (
        .base_c_i(base_sel.col),
        .base_r_i(base_sel.row),
        .idx_i   (k_q),
        .addr_c_o(nb_c),
        .addr_r_o(nb_r),
        .oob_o   (nb_oob)
    );

    assign rd_addrC = (state_q == ST_FETCH) ? nb_c : '0;
    assign rd_addrR = (state_q == ST_FETCH) ? nb_r : '0;

    // Next-state, accumulation and registered-output decode.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        last_cell_d = last_cell_q;
        n_d         = n_q;
        self_d      = self_q;
        prev_oob_d  = prev_oob_q;

        // Read data lags its address by one cycle; consume index k-1 (or 8 in LAST).
        acc_en   = ((state_q == ST_FETCH) && (k_q != '0)) || (state_q == ST_LAST);
        acc_idx  = (state_q == ST_LAST) ? LAST_IDX : k_q - IDX_W'(1);
        acc_live = rd_data & ~prev_oob_q;
        if (acc_en) begin
            if (acc_idx == CTR_IDX) begin
                self_d = acc_live;
            end else if (acc_live && (n_q < CNT_MAX)) begin
                n_d = n_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    k_d     = '0;
                    n_d     = '0;
                    self_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                prev_oob_d = nb_oob;
                if (k_q == '0) begin
                    base_d      = '{col: trav_addrC, row: trav_addrR};
                    last_cell_d = trav_finish;
                end
                if (k_q == LAST_IDX) begin
                    state_d = ST_LAST;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            ST_LAST:    state_d = ST_WRITE;
            ST_WRITE:   state_d = last_cell_q ? ST_DONE : ST_ADVANCE;
            ST_ADVANCE: begin
                state_d = ST_FETCH;
                k_d     = '0;
                n_d     = '0;
                self_d  = 1'b0;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        wr_en_d       = (state_d == ST_WRITE);
        wr_addrC_d    = wr_en_d ? base_q.col : '0;
        wr_addrR_d    = wr_en_d ? base_q.row : '0;
        wr_data_d     = wr_en_d & life_rule(self_d, n_d);
        trav_enable_d = (state_d == ST_ADVANCE);
        busy_d        = (state_d != ST_IDLE);
        gen_done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            base_q        <= '0;
            last_cell_q   <= 1'b0;
            n_q           <= '0;
            self_q        <= 1'b0;
            prev_oob_q    <= 1'b0;
            trav_enable_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addrC_q    <= '0;
            wr_addrR_q    <= '0;
            wr_data_q     <= 1'b0;
            busy_q        <= 1'b0;
            gen_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            base_q        <= base_d;
            last_cell_q   <= last_cell_d;
            n_q           <= n_d;
            self_q        <= self_d;
            prev_oob_q    <= prev_oob_d;
            trav_enable_q <= trav_enable_d;
            wr_en_q       <= wr_en_d;
            wr_addrC_q    <= wr_addrC_d;
            wr_addrR_q    <= wr_addrR_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            gen_done_q    <= gen_done_d;
        end
    end

    assign trav_enable = trav_enable_q;
    assign wr_en       = wr_en_q;
    assign wr_addrC    = wr_addrC_q;
    assign wr_addrR    = wr_addrR_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign gen_done    = gen_done_q;

endmodule

// File: tb/tb_life_cell_update.sv
// Scoreboard bench for life_cell_update with a traverser model and board RAMs.
// Builds with or without LIFE_TORUS_EN; edge expectations follow the macro.
module tb_life_cell_update;

    localparam int W = 8;
    localparam int H = 8;
    localparam int GEN_CYCLES = 768;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] trav_addrC, trav_addrR;
    logic       trav_finish;
    logic       trav_enable;
    logic [7:0] rd_addrC, rd_addrR;
    logic       rd_data;
    logic       wr_en;
    logic [7:0] wr_addrC, wr_addrR;
    logic       wr_data;
    logic       busy;
    logic       gen_done;

    life_cell_update #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .trav_addrC (trav_addrC),
        .trav_addrR (trav_addrR),
        .trav_finish(trav_finish),
        .trav_enable(trav_enable),
        .rd_addrC   (rd_addrC),
        .rd_addrR   (rd_addrR),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addrC   (wr_addrC),
        .wr_addrR   (wr_addrR),
        .wr_data    (wr_data),
        .busy       (busy),
        .gen_done   (gen_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] r;
        logic       d;
    } exp_t;

    exp_t exp_q[$];
    logic cur_b [H][W];
    logic nxt_b [H][W];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   wr_cnt = 0, te_cnt = 0, gd_cnt = 0, gd_cyc = 0, rng_bad = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Traverser model: row-major walk, self-clears once it reaches the last cell.
    assign trav_finish = (trav_addrC == 8'(W - 1)) && (trav_addrR == 8'(H - 1));
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            trav_addrC <= '0;
            trav_addrR <= '0;
        end else if (trav_enable) begin
            if (trav_addrC == 8'(W - 1)) begin
                trav_addrC <= '0;
                trav_addrR <= (trav_addrR == 8'(H - 1)) ? 8'd0 : trav_addrR + 8'd1;
            end else begin
                trav_addrC <= trav_addrC + 8'd1;
            end
        end else if (trav_finish) begin
            trav_addrC <= '0;
            trav_addrR <= '0;
        end
        rd_data <= cur_b[rd_addrR[2:0]][rd_addrC[2:0]];
    end

    // Monitor: pops the scoreboard on every write and tallies pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (busy && ((rd_addrC >= 8'(W)) || (rd_addrR >= 8'(H)))) rng_bad++;
                if (wr_en) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addrC", wr_addrC, e.c);
                        check("wr_addrR", wr_addrR, e.r);
                        check("wr_data", wr_data, e.d);
                        nxt_b[wr_addrR[2:0]][wr_addrC[2:0]] = wr_data;
                    end
                end
                if (trav_enable) te_cnt++;
                if (gen_done) begin
                    gd_cnt++;
                    gd_cyc = cyc - start_cyc + 1;
                end
            end
        end
    end

    function automatic logic life_next(input int c, input int r);
        int n;
        int cc;
        int rr;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    cc = c + dc;
                    rr = r + dr;
`ifdef LIFE_TORUS_EN
                    cc = (cc + W) % W;
                    rr = (rr + H) % H;
                    n += int'(cur_b[rr][cc]);
`else
                    if (cc >= 0 && cc < W && rr >= 0 && rr < H) n += int'(cur_b[rr][cc]);
`endif
                end
            end
        end
        return (n == 3) || (cur_b[r][c] && n == 2);
    endfunction

    function automatic int live_count();
        int n;
        n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                n += int'(nxt_b[r][c]);
        return n;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                cur_b[r][c] = 1'b0;
    endtask

    task automatic set_cell(input int c, input int r);
        cur_b[r][c] = 1'b1;
    endtask

    task automatic push_expected();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back('{c: 8'(c), r: 8'(r), d: life_next(c, r)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    // One full generation; optionally re-pulses start at cycles 5 and 400.
    task automatic run_gen(input string tag, input bit extra_starts);
        int wr0, te0, gd0;
        wr0 = wr_cnt; te0 = te_cnt; gd0 = gd_cnt;
        push_expected();
        pulse_start();
        if (extra_starts) begin
            fork
                begin
                    repeat (4) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                    repeat (394) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < GEN_CYCLES + 100 && gd_cnt == gd0; i++) begin
            @(posedge clk); #2;
        end
        check({tag, "_done_seen"}, gd_cnt - gd0, 1);
        check({tag, "_done_cycle"}, gd_cyc, GEN_CYCLES);
        check({tag, "_busy_after_done"}, busy, 0);
        check({tag, "_writes"}, wr_cnt - wr0, 64);
        check({tag, "_trav_enables"}, te_cnt - te0, 63);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
        if (extra_starts) begin
            repeat (30) @(posedge clk);
            #2;
            check({tag, "_single_done"}, gd_cnt - gd0, 1);
            check({tag, "_idle_after"}, busy, 0);
        end
    endtask

    task automatic set_blinker();
        clear_board();
        set_cell(3, 2); set_cell(3, 3); set_cell(3, 4);
    endtask

    task automatic check_blinker_result(input string tag);
        check({tag, "_live"}, live_count(), 3);
        check({tag, "_c2r3"}, nxt_b[3][2], 1);
        check({tag, "_c3r3"}, nxt_b[3][3], 1);
        check({tag, "_c4r3"}, nxt_b[3][4], 1);
    endtask

    initial begin
        int wr0, gd0;
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wr0, gd0;
        rst = 1'b1;
        start = 1'b0;
        clear_board();
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {trav_enable, rd_addrC, rd_addrR, wr_en, wr_addrC, wr_addrR,
                                wr_data, busy, gen_done}, 0);
        #1 rst = 1'b0;

        set_blinker();
        run_gen("blinker", 1'b0);
        check_blinker_result("blinker");

        clear_board();
        set_cell(0, 0); set_cell(1, 0); set_cell(0, 1); set_cell(1, 1);
        run_gen("block", 1'b0);
        check("block_live", live_count(), 4);
        check("block_c0r0", nxt_b[0][0], 1);
        check("block_c1r1", nxt_b[1][1], 1);

        clear_board();
        set_cell(7, 0); set_cell(7, 7); set_cell(0, 7);
        run_gen("corners", 1'b0);
`ifdef LIFE_TORUS_EN
        check("corners_live", live_count(), 4);
        check("corners_c0r0_born", nxt_b[0][0], 1);
`else
        check("corners_live", live_count(), 0);
        check("corners_c0r0_dead", nxt_b[0][0], 0);
`endif

        set_blinker();
        run_gen("restart_ignored", 1'b1);
        check_blinker_result("restart_ignored");

        // Reset in cycle 300 of a generation aborts it.
        push_expected();
        pulse_start();
        repeat (299) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_outputs", {trav_enable, rd_addrC, rd_addrR, wr_en, wr_addrC, wr_addrR,
                                wr_data, busy, gen_done}, 0);
        exp_q.delete();
        wr0 = wr_cnt; gd0 = gd_cnt;
        repeat (800) @(posedge clk);
        #2;
        check("abort_no_done", gd_cnt - gd0, 0);
        check("abort_no_write", wr_cnt - wr0, 0);
        run_gen("after_abort", 1'b0);
        check_blinker_result("after_abort");

        clear_board();
        run_gen("all_dead", 1'b0);
        check("all_dead_live", live_count(), 0);

        check("rd_addr_range", rng_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
